// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// memory handshakes, retired-instruction counter and sticky timeout error.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  ctrl,
  input  logic        cond_true,
  input  logic        zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        flag_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          st;
  logic            run;
  logic [TO_W-1:0] wcnt;

  logic mem_rd, mem_wr, reg_wr, ubranch, branch, branch0, breg, set_flag;
  logic taken, mem_op;
  logic [1:0] pc_sel;
  logic unused_link;

  assign mem_rd   = ctrl[8];
  assign mem_wr   = ctrl[7];
  assign reg_wr   = ctrl[6];
  assign ubranch  = ctrl[5];
  assign branch   = ctrl[4];
  assign branch0  = ctrl[3];
  assign breg     = ctrl[2];
  assign set_flag = ctrl[0];
  // link only steers the datapath write-data mux; the sequencer ignores it
  assign unused_link = ctrl[1];

  assign taken  = ubranch | (branch & cond_true) | (branch0 & zero);
  assign pc_sel = breg ? 2'b10 : (taken ? 2'b01 : 2'b00);
  assign mem_op = mem_rd | mem_wr;
  assign state  = st;

  // Strobes decoded from current state and inputs, all held low until run
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    flag_we  = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'b00;
    if (run) begin
      case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          flag_we = set_flag;
          if (!mem_op && !reg_wr) begin
            pc_we  = 1'b1;
            pc_src = pc_sel;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_wr;
          if (dmem_ack && !mem_rd) begin
            pc_we  = 1'b1;
            pc_src = 2'b00;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          pc_src = pc_sel;
        end
        default: ;
      endcase
    end
  end

  // State sequencing, wait counter, retire count and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_FETCH;
      run         <= 1'b0;
      wcnt        <= '0;
      retired     <= '0;
      timeout_err <= 1'b0;
    end else begin
      run <= 1'b1;
      if (pc_we) retired <= retired + 32'd1;
      case (st)
        S_FETCH: begin
          if (run) begin
            // an ack in the final allowed cycle beats the timeout
            if (imem_ack) begin
              st <= S_DECODE;
            end else if (wcnt == TO_LAST) begin
              st          <= S_ERR;
              timeout_err <= 1'b1;
            end else begin
              wcnt <= wcnt + TO_W'(1);
            end
          end
        end
        S_DECODE: st <= S_EXEC;
        S_EXEC: begin
          wcnt <= '0;
          if (mem_op)      st <= S_MEM;
          else if (reg_wr) st <= S_WB;
          else             st <= S_FETCH;
        end
        S_MEM: begin
          if (dmem_ack) begin
            wcnt <= '0;
            st   <= mem_rd ? S_WB : S_FETCH;
          end else if (wcnt == TO_LAST) begin
            st          <= S_ERR;
            timeout_err <= 1'b1;
          end else begin
            wcnt <= wcnt + TO_W'(1);
          end
        end
        S_WB: begin
          wcnt <= '0;
          st   <= S_FETCH;
        end
        S_ERR:   st <= S_ERR;
        default: st <= S_ERR;
      endcase
    end
  end

endmodule
